joy_scan_md: RTL and testbench

Parametrised successor to the shift-register joystick decoder for the ZXDOS+ board family. Reads NUM_JOY Megadrive/passive pads through one chained 74x165-style parallel-in/serial-out shifter. The block drives the pad select line itself and runs the full 8-phase 6-button protocol, so it does not depend on video hsync. Outputs per-pad MXYZ SACB RLDU in negative logic, a detected pad type, and debounced buttons to the core's input logic.

---
 rtl/joy_pkg.sv | 43 ++++
 rtl/joy_md_decode.sv | 123 ++++++++++++
 rtl/joy_scan_md.sv | 176 +++++++++++++++++
 tb/tb_joy_scan_md.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/joy_pkg.sv
// Shared definitions for the Megadrive/passive shift-chain joystick scanner.
// Holds shifter slot positions, output bit positions, pad type codes, the
// protocol phase count and the scan engine state encoding.
package joy_pkg;

  // Shifter slot positions within one pad's group of slots
  localparam int SLOT_U  = 0;
  localparam int SLOT_D  = 1;
  localparam int SLOT_L  = 2;
  localparam int SLOT_R  = 3;
  localparam int SLOT_P6 = 4;  // B (sel=1) / A (sel=0)
  localparam int SLOT_P9 = 5;  // C (sel=1) / Start (sel=0)

  // Output bit positions within a pad's 12-bit word: MXYZ SACB RLDU
  localparam int JB_U = 0;
  localparam int JB_D = 1;
  localparam int JB_L = 2;
  localparam int JB_R = 3;
  localparam int JB_B = 4;
  localparam int JB_C = 5;
  localparam int JB_A = 6;
  localparam int JB_S = 7;
  localparam int JB_Z = 8;
  localparam int JB_Y = 9;
  localparam int JB_X = 10;
  localparam int JB_M = 11;

  // Detected pad type
  localparam logic [1:0] JT_PASSIVE = 2'b00;
  localparam logic [1:0] JT_3B      = 2'b01;
  localparam logic [1:0] JT_6B      = 2'b10;

  localparam int NUM_PHASES = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_GAP    = 3'd4
  } eng_state_t;

endpackage

// File: rtl/joy_md_decode.sv
// Per-pad Megadrive protocol decoder.
// Captures the six shifter slots of one pad at the end of each protocol
// phase, derives the 3-button (md) and 6-button (six) flags, builds the
// 12-bit negative-logic button word on commit and filters every bit through
// a DEBOUNCE-deep history before it reaches joy_o.
// Ports:
//   clk, reset_n   system clock, synchronous active-low reset
//   slots[5:0]     this pad's slots from the phase just shifted (U D L R p6 p9)
//   phase[2:0]     protocol phase that just finished shifting
//   phase_done     one-cycle strobe: slots/phase valid
//   commit         one-cycle strobe: publish the scan result
//   joy_o[11:0]    debounced MXYZ SACB RLDU, 0 = pressed
//   joy_type[1:0]  detected pad type, updated on commit without debounce
module joy_md_decode
  import joy_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  slots,
  input  logic [2:0]  phase,
  input  logic        phase_done,
  input  logic        commit,
  output logic [11:0] joy_o,
  output logic [1:0]  joy_type
);

  logic [5:0]  cap0;       // phase 0: U D L R B C
  logic        cap_a;
  logic        cap_s;
  logic [3:0]  cap6;       // phase 6: Z Y X M on the U D L R slots
  logic        md;
  logic        six;

  logic [11:0] hist     [DEBOUNCE];
  logic [11:0] hist_nxt [DEBOUNCE];
  logic [11:0] word;
  logic [11:0] all_one;
  logic [11:0] any_one;
  logic [11:0] agree;
  logic [1:0]  type_nxt;

  always_comb begin
    word     = '1;
    type_nxt = JT_PASSIVE;
    word[JB_U] = cap0[SLOT_U];
    word[JB_D] = cap0[SLOT_D];
    word[JB_L] = cap0[SLOT_L];
    word[JB_R] = cap0[SLOT_R];
    word[JB_B] = cap0[SLOT_P6];
    word[JB_C] = cap0[SLOT_P9];
    if (md) begin
      word[JB_A] = cap_a;
      word[JB_S] = cap_s;
      type_nxt   = JT_3B;
      if (six) begin
        word[JB_Z] = cap6[SLOT_U];
        word[JB_Y] = cap6[SLOT_D];
        word[JB_X] = cap6[SLOT_L];
        word[JB_M] = cap6[SLOT_R];
        type_nxt   = JT_6B;
      end
    end

    // History after this commit: newest entry first
    hist_nxt[0] = word;
    for (int k = 1; k < DEBOUNCE; k++) begin
      hist_nxt[k] = hist[k-1];
    end

    all_one = '1;
    any_one = '0;
    for (int k = 0; k < DEBOUNCE; k++) begin
      all_one = all_one & hist_nxt[k];
      any_one = any_one | hist_nxt[k];
    end
    // A bit may move only when every history entry holds the same value
    agree = all_one | ~any_one;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cap0     <= '1;
      cap_a    <= 1'b1;
      cap_s    <= 1'b1;
      cap6     <= '1;
      md       <= 1'b0;
      six      <= 1'b0;
      joy_o    <= '1;
      joy_type <= JT_PASSIVE;
      for (int k = 0; k < DEBOUNCE; k++) begin
        hist[k] <= '1;
      end
    end else begin
      if (phase_done) begin
        case (phase)
          3'd0: cap0 <= slots;
          3'd1: begin
            // A Megadrive pad pulls L and R low while select is low
            md <= ~slots[SLOT_L] & ~slots[SLOT_R];
            if (!slots[SLOT_L] && !slots[SLOT_R]) begin
              cap_a <= slots[SLOT_P6];
              cap_s <= slots[SLOT_P9];
            end
          end
          // Third low phase of a 6-button pad drives all directions low
          3'd5: six <= md & (slots[3:0] == 4'b0000);
          3'd6: if (six) cap6 <= slots[3:0];
          default: ;
        endcase
      end
      if (commit) begin
        for (int k = 0; k < DEBOUNCE; k++) begin
          hist[k] <= hist_nxt[k];
        end
        joy_o    <= (joy_o & ~agree) | (word & agree);
        joy_type <= type_nxt;
      end
    end
  end

endmodule

// File: rtl/joy_scan_md.sv
// Megadrive/passive joystick scanner for a chained 74x165-style shifter.
// Drives the pad select line through the 8-phase 6-button protocol, loads
// and shifts the chain once per phase, and publishes per-pad debounced
// buttons and pad type after an idle gap that lets 6-button pads reset.
// Ports:
//   clk, reset_n   system clock, synchronous active-low reset
//   scan_en        1 = scan continuously, 0 = stop after the current scan
//   joy_data       serial data from the shifter
//   joy_clk        shifter clock, idles low, shifts on rising edge
//   joy_load_n     shifter parallel load, active low
//   joy_sel        pad select line to all pads
//   joy_o          pad n at [12n+11:12n]: MXYZ SACB RLDU, 0 = pressed
//   joy_type       pad n at [2n+1:2n]: 00 passive, 01 3-button, 10 6-button
//   frame_done     one-cycle pulse when a scan result is committed
module joy_scan_md
  import joy_pkg::*;
#(
  parameter int NUM_JOY      = 2,
  parameter int BITS_PER_JOY = 8,
  parameter int CLK_DIV      = 8,
  parameter int SETTLE_CYC   = 64,
  parameter int IDLE_CYC     = 24000,
  parameter int DEBOUNCE     = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    scan_en,
  input  logic                    joy_data,
  output logic                    joy_clk,
  output logic                    joy_load_n,
  output logic                    joy_sel,
  output logic [NUM_JOY*12-1:0]   joy_o,
  output logic [NUM_JOY*2-1:0]    joy_type,
  output logic                    frame_done
);

  localparam int TMR_MAX = (SETTLE_CYC > IDLE_CYC)
                         ? ((SETTLE_CYC > CLK_DIV) ? SETTLE_CYC : CLK_DIV)
                         : ((IDLE_CYC > CLK_DIV) ? IDLE_CYC : CLK_DIV);
  localparam int TMR_W  = $clog2(TMR_MAX);
  localparam int SLOT_W = $clog2(BITS_PER_JOY);
  localparam int PAD_W  = (NUM_JOY > 1) ? $clog2(NUM_JOY) : 1;

  localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0]  DIV_LAST    = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0]  DIV_HALF    = TMR_W'(CLK_DIV / 2);
  localparam logic [TMR_W-1:0]  SAMPLE_AT   = TMR_W'(CLK_DIV / 2 - 1);
  localparam logic [TMR_W-1:0]  GAP_LAST    = TMR_W'(IDLE_CYC - 1);
  localparam logic [SLOT_W-1:0] SLOT_FIRST  = SLOT_W'(BITS_PER_JOY - 1);
  localparam logic [PAD_W-1:0]  PAD_LAST    = PAD_W'(NUM_JOY - 1);
  localparam logic [2:0]        PHASE_LAST  = 3'(NUM_PHASES - 1);

  eng_state_t        state;
  logic [2:0]        phase;
  logic [TMR_W-1:0]  tmr;
  logic [SLOT_W-1:0] slot_cnt;
  logic [PAD_W-1:0]  pad_cnt;
  logic [5:0]        slot_reg [NUM_JOY];

  logic settle_end;
  logic load_end;
  logic bit_end;
  logic shift_end;
  logic sample;
  logic gap_end;

  assign settle_end = (state == ST_SETTLE) && (tmr == SETTLE_LAST);
  assign load_end   = (state == ST_LOAD)   && (tmr == DIV_LAST);
  assign bit_end    = (state == ST_SHIFT)  && (tmr == DIV_LAST);
  assign shift_end  = bit_end && (slot_cnt == '0) && (pad_cnt == PAD_LAST);
  // Sample on the last cycle of the low half, before the rising edge
  assign sample     = (state == ST_SHIFT)  && (tmr == SAMPLE_AT);
  assign gap_end    = (state == ST_GAP)    && (tmr == GAP_LAST);

  // Pin levels follow the engine state directly so reset idles them at once
  assign joy_sel    = ((state == ST_SETTLE) || (state == ST_LOAD) || (state == ST_SHIFT))
                    ? ~phase[0] : 1'b1;
  assign joy_load_n = (state != ST_LOAD);
  assign joy_clk    = (state == ST_SHIFT) && (tmr >= DIV_HALF);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      phase      <= 3'd0;
      tmr        <= '0;
      slot_cnt   <= SLOT_FIRST;
      pad_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= gap_end;
      tmr        <= tmr + 1'b1;
      case (state)
        ST_IDLE: begin
          tmr <= '0;
          if (scan_en) begin
            phase <= 3'd0;
            state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_end) begin
            tmr   <= '0;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (load_end) begin
            tmr      <= '0;
            slot_cnt <= SLOT_FIRST;
            pad_cnt  <= '0;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bit_end) begin
            tmr <= '0;
            if (slot_cnt == '0) begin
              slot_cnt <= SLOT_FIRST;
              if (pad_cnt == PAD_LAST) begin
                pad_cnt <= '0;
                if (phase == PHASE_LAST) begin
                  state <= ST_GAP;
                end else begin
                  phase <= phase + 3'd1;
                  state <= ST_SETTLE;
                end
              end else begin
                pad_cnt <= pad_cnt + 1'b1;
              end
            end else begin
              slot_cnt <= slot_cnt - 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (gap_end) begin
            tmr   <= '0;
            state <= ST_IDLE;
          end
        end
        default: begin
          tmr   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Serial capture: only slots 0..5 of each pad are kept; every kept slot is
  // rewritten in each phase, so no clearing is needed between phases.
  always_ff @(posedge clk) begin
    if (sample && (slot_cnt < SLOT_W'(6))) begin
      for (int p = 0; p < NUM_JOY; p++) begin
        if (pad_cnt == PAD_W'(p)) begin
          slot_reg[p][slot_cnt[2:0]] <= joy_data;
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_JOY; p++) begin : g_pad
    joy_md_decode #(
      .DEBOUNCE(DEBOUNCE)
    ) u_dec (
      .clk        (clk),
      .reset_n    (reset_n),
      .slots      (slot_reg[p]),
      .phase      (phase),
      .phase_done (shift_end),
      .commit     (gap_end),
      .joy_o      (joy_o[12*p +: 12]),
      .joy_type   (joy_type[2*p +: 2])
    );
  end

endmodule

// File: tb/tb_joy_scan_md.sv
// Directed bench for joy_scan_md with a two-pad 74x165 chain model whose
// pads can act as passive, 3-button or 6-button Megadrive controllers.
module tb_joy_scan_md;
  import joy_pkg::*;

  localparam int NUM_JOY    = 2;
  localparam int BPJ        = 8;
  localparam int CLK_DIV    = 4;
  localparam int SETTLE_CYC = 8;
  localparam int IDLE_CYC   = 200;
  localparam int DEBOUNCE   = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        scan_en = 1'b0;
  logic        joy_data;
  logic        joy_clk;
  logic        joy_load_n;
  logic        joy_sel;
  logic [23:0] joy_o;
  logic [3:0]  joy_type;
  logic        frame_done;

  always #5 clk = ~clk;

  joy_scan_md #(
    .NUM_JOY(NUM_JOY), .BITS_PER_JOY(BPJ), .CLK_DIV(CLK_DIV),
    .SETTLE_CYC(SETTLE_CYC), .IDLE_CYC(IDLE_CYC), .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .scan_en(scan_en), .joy_data(joy_data),
    .joy_clk(joy_clk), .joy_load_n(joy_load_n), .joy_sel(joy_sel),
    .joy_o(joy_o), .joy_type(joy_type), .frame_done(frame_done)
  );

  // ---------------- pad + shifter model ----------------
  int          mode [2];      // 0 passive, 1 3-button, 2 6-button
  logic [11:0] press [2];     // 1 = pressed, JB_* positions
  logic [2:0]  lows = 3'd0;   // select falling edges since the pad's timeout
  int          high_run = 0;
  logic        psel = 1'b1;
  logic        pclk = 1'b0;
  logic [15:0] sr = 16'hFFFF;

  function automatic logic [7:0] pad_slots(input int m, input logic [11:0] pr,
                                           input logic sel, input logic [2:0] n);
    logic [11:0] k;
    logic [7:0]  s;
    k = ~pr;
    s = 8'hFF;
    if (m == 0 || (sel && !(m == 2 && n == 3)))
      s[5:0] = {k[JB_C], k[JB_B], k[JB_R], k[JB_L], k[JB_D], k[JB_U]};
    else if (sel)
      s[5:0] = {k[JB_C], k[JB_B], k[JB_M], k[JB_X], k[JB_Y], k[JB_Z]};
    else if (m == 2 && n == 3)
      s[5:0] = {k[JB_S], k[JB_A], 4'b0000};
    else if (m == 2 && n >= 4)
      s[5:0] = {k[JB_S], k[JB_A], 4'b1111};
    else
      s[5:0] = {k[JB_S], k[JB_A], 2'b00, k[JB_D], k[JB_U]};
    return s;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      lows     <= 3'd0;
      high_run <= 0;
    end else begin
      if (psel && !joy_sel) lows <= lows + 3'd1;
      if (joy_sel) begin
        high_run <= high_run + 1;
        if (high_run > 150) lows <= 3'd0;
      end else begin
        high_run <= 0;
      end
    end
    psel <= joy_sel;
    if (!joy_load_n)
      sr <= {pad_slots(mode[0], press[0], joy_sel, lows),
             pad_slots(mode[1], press[1], joy_sel, lows)};
    else if (joy_clk && !pclk)
      sr <= {sr[14:0], 1'b1};
    pclk <= joy_clk;
  end

  assign joy_data = sr[15];

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 2000);
    check(tag, 32'(frame_done), 32'd1);
  endtask

  task automatic set_pads(input int m0, input logic [11:0] p0, input int m1, input logic [11:0] p1);
    mode[0] = m0; press[0] = p0;
    mode[1] = m1; press[1] = p1;
  endtask

  int          rises [8];
  int          cyc, nload, lowrun, lowmin, lowmax, selrun, falls;
  logic [7:0]  selseq;
  logic        pclk_m, pload_m, psel_m, bad, first_sel, got_first;
  logic [11:0] pb;

  initial begin
    set_pads(0, 12'h000, 0, 12'h000);

    // ---- reset state ----
    repeat (5) @(negedge clk);
    check("rst_joy_o", 32'(joy_o), 32'hFFFFFF);
    check("rst_type", 32'(joy_type), 32'h0);
    check("rst_sel", 32'(joy_sel), 32'd1);
    check("rst_load_n", 32'(joy_load_n), 32'd1);
    check("rst_joy_clk", 32'(joy_clk), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_no_scan_load_n", 32'(joy_load_n), 32'd1);
    check("idle_no_scan_fd", 32'(frame_done), 32'd0);

    // ---- passive pad 0 with U held, plus scan timing ----
    pb = '0; pb[JB_U] = 1'b1;
    set_pads(0, pb, 0, 12'h000);
    scan_en = 1'b1;
    wait_frame("f1_wait");
    check("f1_type", 32'(joy_type), 32'h0);
    check("f1_pad0_debounced", 32'(joy_o[11:0]), 32'hFFF);

    cyc = 0; nload = 0; lowrun = 0; lowmin = 1000; lowmax = 0; selrun = 0;
    selseq = '0; pclk_m = 1'b0; pload_m = 1'b1;
    for (int i = 0; i < 8; i++) rises[i] = 0;
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (joy_clk && !pclk_m && nload > 0 && nload <= 8) rises[nload-1]++;
      if (!joy_load_n) begin
        if (pload_m && nload < 8) selseq[nload] = joy_sel;
        if (pload_m) nload++;
        lowrun++;
      end else if (!pload_m) begin
        if (lowrun < lowmin) lowmin = lowrun;
        if (lowrun > lowmax) lowmax = lowrun;
        lowrun = 0;
      end
      selrun  = joy_sel ? selrun + 1 : 0;
      pclk_m  = joy_clk;
      pload_m = joy_load_n;
      if (frame_done) break;
    end
    check("tm_frame_done_seen", 32'(frame_done), 32'd1);
    check("tm_period", 32'(cyc), 32'd809);
    check("tm_loads", 32'(nload), 32'd8);
    check("tm_load_low_min", 32'(lowmin), 32'd4);
    check("tm_load_low_max", 32'(lowmax), 32'd4);
    for (int i = 0; i < 8; i++) check($sformatf("tm_rises_ph%0d", i), 32'(rises[i]), 32'd16);
    check("tm_sel_seq", 32'(selseq), 32'h55);
    check("tm_gap_sel_high", 32'(selrun), 32'd201);

    wait_frame("f3_wait");
    check("f3_pad0_still_fff", 32'(joy_o[11:0]), 32'hFFF);
    wait_frame("f4_wait");
    check("f4_pad0_u", 32'(joy_o[11:0]), 32'hFFE);
    check("f4_pad1", 32'(joy_o[23:12]), 32'hFFF);
    check("f4_type", 32'(joy_type), 32'h0);

    // ---- 3-button pads, A held on pad 0 ----
    pb = '0; pb[JB_A] = 1'b1;
    set_pads(1, pb, 1, 12'h000);
    wait_frame("g1_wait");
    check("g1_type_immediate", 32'(joy_type), 32'h5);
    check("g1_pad0_held", 32'(joy_o[11:0]), 32'hFFE);
    wait_frame("g2_wait");
    wait_frame("g3_wait");
    wait_frame("g4_wait");
    check("g4_pad0_a", 32'(joy_o[11:0]), 32'hFBF);
    check("g4_bit6", 32'(joy_o[6]), 32'd0);
    check("g4_mxyz", 32'(joy_o[11:8]), 32'hF);
    check("g4_pad1", 32'(joy_o[23:12]), 32'hFFF);

    // ---- 6-button pad 1 with X held, pad 0 passive idle ----
    pb = '0; pb[JB_X] = 1'b1;
    set_pads(0, 12'h000, 2, pb);
    wait_frame("h1_wait");
    check("h1_type", 32'(joy_type), 32'h8);
    wait_frame("h2_wait");
    wait_frame("h3_wait");
    wait_frame("h4_wait");
    check("h4_pad1_x", 32'(joy_o[23:12]), 32'hBFF);
    check("h4_bit22", 32'(joy_o[22]), 32'd0);
    check("h4_pad0", 32'(joy_o[11:0]), 32'hFFF);
    check("h4_type", 32'(joy_type), 32'h8);

    // ---- debounce: one-scan glitch on B, then B held ----
    pb = '0; pb[JB_B] = 1'b1;
    set_pads(0, pb, 0, 12'h000);
    wait_frame("k1_wait");
    check("k1_glitch_b", 32'(joy_o[4]), 32'd1);
    set_pads(0, 12'h000, 0, 12'h000);
    wait_frame("k2_wait");
    check("k2_pad0", 32'(joy_o[11:0]), 32'hFFF);
    set_pads(0, pb, 0, 12'h000);
    wait_frame("k3_wait");
    wait_frame("k4_wait");
    wait_frame("k5_wait");
    check("k5_b_third", 32'(joy_o[4]), 32'd1);
    wait_frame("k6_wait");
    check("k6_b_fourth", 32'(joy_o[11:0]), 32'hFEF);
    check("k6_pad1", 32'(joy_o[23:12]), 32'hFFF);
    check("k6_type", 32'(joy_type), 32'h0);

    // ---- scan_en dropped mid-scan ----
    repeat (300) @(negedge clk);
    scan_en = 1'b0;
    wait_frame("stop_commit_wait");
    check("stop_pad0", 32'(joy_o[11:0]), 32'hFEF);
    bad = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (frame_done || !joy_sel || !joy_load_n || joy_clk) bad = 1'b1;
    end
    check("stop_stays_idle", 32'(bad), 32'd0);

    // ---- reset during phase 3 SHIFT ----
    pb = '0; pb[JB_A] = 1'b1;
    set_pads(1, pb, 2, 12'h000);
    scan_en = 1'b1;
    falls = 0; psel_m = joy_sel; cyc = 0;
    while (falls < 2 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (psel_m && !joy_sel) falls++;
      psel_m = joy_sel;
    end
    check("r_phase3_reached", 32'(falls), 32'd2);
    cyc = 0;
    while (joy_load_n && cyc < 200) begin @(negedge clk); cyc++; end
    while (!joy_load_n && cyc < 200) begin @(negedge clk); cyc++; end
    repeat (20) @(negedge clk);
    check("r_in_shift_sel", 32'(joy_sel), 32'd0);
    reset_n = 1'b0;
    @(negedge clk);
    check("r_joy_o", 32'(joy_o), 32'hFFFFFF);
    check("r_type", 32'(joy_type), 32'h0);
    check("r_sel", 32'(joy_sel), 32'd1);
    check("r_load_n", 32'(joy_load_n), 32'd1);
    check("r_joy_clk", 32'(joy_clk), 32'd0);
    check("r_frame_done", 32'(frame_done), 32'd0);
    reset_n = 1'b1;
    bad = 1'b0; got_first = 1'b0; first_sel = 1'b0; cyc = 0;
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (!joy_load_n && !got_first) begin
        got_first = 1'b1;
        first_sel = joy_sel;
      end
      if (frame_done) break;
      if (joy_o !== 24'hFFFFFF) bad = 1'b1;
    end
    check("r_restart_commit", 32'(frame_done), 32'd1);
    check("r_restart_phase0_sel", 32'(first_sel), 32'd1);
    check("r_held_fff", 32'(bad), 32'd0);
    check("r_commit_joy_o", 32'(joy_o), 32'hFFFFFF);
    check("r_commit_type", 32'(joy_type), 32'h9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
